// File: rtl/microsequencer.sv
// Control-unit next-address engine: steps the control-ROM address each clock per the ROM sel field,
// with a memory-wait watchdog and a sticky error trap that only clr releases.
module microsequencer #(
    parameter int SW          = 7,
    parameter int RESET_STATE = 0,
    parameter int FETCH_STATE = 1,
    parameter int ERROR_STATE = 127,
    parameter int TIMEOUT     = 15
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [SW-1:0] encoder_IN,
    input  logic [2:0]    sel_IN,
    input  logic [SW-1:0] next_IN,
    input  logic          inv_IN,
    input  logic          cond_IN,
    input  logic          moc_IN,
    output logic [SW-1:0] state_OUT,
    output logic          decode_OUT,
    output logic          err_OUT
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    localparam logic [SW-1:0] ONE       = SW'(1);
    localparam logic [SW-1:0] RST_ADDR  = SW'(RESET_STATE);
    localparam logic [SW-1:0] FETCH_ADDR = SW'(FETCH_STATE);
    localparam logic [SW-1:0] ERR_ADDR  = SW'(ERROR_STATE);
    localparam logic [CW-1:0] LAST_MISS = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        SEL_INCR    = 3'b000,
        SEL_DECODE  = 3'b001,
        SEL_JUMP    = 3'b010,
        SEL_WAITMOC = 3'b011,
        SEL_COND    = 3'b100,
        SEL_FETCH   = 3'b101
    } sel_t;

    logic [SW-1:0] r_state;
    logic          r_decode;
    logic          r_err;
    logic [CW-1:0] r_wait_cnt;

    logic [SW-1:0] w_state_nxt;
    logic          w_decode_nxt;
    logic          w_err_nxt;
    logic [CW-1:0] w_wait_cnt_nxt;
    logic [SW-1:0] w_state_inc;
    logic          w_cond_pass;

    assign w_state_inc = r_state + ONE;
    assign w_cond_pass = cond_IN ^ inv_IN;

    // Next-state selection; the trap check comes first so nothing else can move a trapped machine.
    always_comb begin
        // NOTE: every output of this block gets a default up front so no path leaves one unassigned (no latches).
        w_state_nxt    = r_state;
        w_decode_nxt   = 1'b0;
        w_err_nxt      = r_err;
        w_wait_cnt_nxt = '0;

        if (r_err) begin
            w_state_nxt = ERR_ADDR;
        end else begin
            case (sel_IN)
                SEL_INCR: begin
                    w_state_nxt = w_state_inc;
                end
                SEL_DECODE: begin
                    if (encoder_IN == '0) begin
                        w_state_nxt = FETCH_ADDR;
                    end else begin
                        w_state_nxt  = encoder_IN;
                        w_decode_nxt = 1'b1;
                    end
                end
                SEL_JUMP: begin
                    w_state_nxt = next_IN;
                end
                SEL_WAITMOC: begin
                    if (moc_IN) begin
                        w_state_nxt = w_state_inc;
                    end else if (r_wait_cnt == LAST_MISS) begin
                        w_state_nxt = ERR_ADDR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + CW'(1);
                    end
                end
                SEL_COND: begin
                    w_state_nxt = w_cond_pass ? next_IN : w_state_inc;
                end
                SEL_FETCH: begin
                    w_state_nxt = FETCH_ADDR;
                end
                default: begin
                    w_state_nxt = ERR_ADDR;
                    w_err_nxt   = 1'b1;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= RST_ADDR;
            r_decode   <= 1'b0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_decode   <= w_decode_nxt;
            r_err      <= w_err_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    assign state_OUT  = r_state;
    assign decode_OUT = r_decode;
    assign err_OUT    = r_err;

endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural model of the sequencing rules.
module tb_microsequencer;

    localparam int SW      = 7;
    localparam int TIMEOUT = 15;
    localparam int NSTATES = 1 << SW;
    localparam int ERR_ST  = 127;

    logic          clk;
    logic          clr;
    logic [SW-1:0] encoder_IN;
    logic [2:0]    sel_IN;
    logic [SW-1:0] next_IN;
    logic          inv_IN;
    logic          cond_IN;
    logic          moc_IN;
    logic [SW-1:0] state_OUT;
    logic          decode_OUT;
    logic          err_OUT;

    microsequencer #(
        .SW(SW), .RESET_STATE(0), .FETCH_STATE(1), .ERROR_STATE(ERR_ST), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .clr(clr), .encoder_IN(encoder_IN), .sel_IN(sel_IN), .next_IN(next_IN),
        .inv_IN(inv_IN), .cond_IN(cond_IN), .moc_IN(moc_IN),
        .state_OUT(state_OUT), .decode_OUT(decode_OUT), .err_OUT(err_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model: expected outputs after the most recent clock edge.
    int m_state = 0;
    bit m_err   = 1'b0;
    bit m_dec   = 1'b0;
    int m_miss  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_err   = 1'b0;
        m_dec   = 1'b0;
        m_miss  = 0;
    endtask

    task automatic model_step(input int s, input int enc, input int nxt, input bit inv, input bit cond,
                              input bit moc);
        m_dec = 1'b0;
        if (m_err) begin
            m_state = ERR_ST;
        end else if (s >= 6) begin
            m_state = ERR_ST;
            m_err   = 1'b1;
        end else if (s == 3 && !moc) begin
            m_miss++;
            if (m_miss == TIMEOUT) begin
                m_state = ERR_ST;
                m_err   = 1'b1;
            end
        end else begin
            case (s)
                0, 3: m_state = (m_state + 1) % NSTATES;
                1: begin
                    if (enc == 0) m_state = 1;
                    else begin
                        m_state = enc;
                        m_dec   = 1'b1;
                    end
                end
                2: m_state = nxt;
                4: m_state = (cond != inv) ? nxt : (m_state + 1) % NSTATES;
                default: m_state = 1;
            endcase
        end
        if (s != 3 || moc || m_err) m_miss = 0;
    endtask

    task automatic drive(input int s, input int enc = 0, input int nxt = 0, input bit inv = 0,
                         input bit cond = 0, input bit moc = 0);
        sel_IN     = 3'(s);
        encoder_IN = SW'(enc);
        next_IN    = SW'(nxt);
        inv_IN     = inv;
        cond_IN    = cond;
        moc_IN     = moc;
        @(posedge clk);
        model_step(s, enc, nxt, inv, cond, moc);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        model_reset();
        #1;
        check("clr_state", state_OUT, 0);
        check("clr_err", err_OUT, 0);
        check("clr_dec", decode_OUT, 0);
        @(negedge clk);
        #1;
        clr = 1'b0;
    endtask

    // Single compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_state", state_OUT, m_state);
            check("cyc_err", err_OUT, m_err);
            check("cyc_dec", decode_OUT, m_dec);
        end
    end

    initial begin
        int prev_sel;
        int moc_bias;
        int s;
        clr = 1'b1;
        sel_IN = '0; encoder_IN = '0; next_IN = '0;
        inv_IN = 1'b0; cond_IN = 1'b0; moc_IN = 1'b0;
        model_reset();
        #3;
        check("rst_state", state_OUT, 0);
        check("rst_err", err_OUT, 0);
        check("rst_dec", decode_OUT, 0);
        repeat (2) @(negedge clk);
        #1;
        clr = 1'b0;
        chk_en = 1'b1;

        // Decode
        drive(5);                 check("fetch", state_OUT, 1);
        drive(1, 43);             check("dec43_state", state_OUT, 43); check("dec43_pulse", decode_OUT, 1);
        drive(5);                 check("refetch", state_OUT, 1);      check("dec_drop", decode_OUT, 0);
        drive(1, 0);              check("dec0_state", state_OUT, 1);   check("dec0_pulse", decode_OUT, 0);

        // Wrap and conditional branch
        drive(2, 0, 127);         check("jump127", state_OUT, 127);    check("jump127_err", err_OUT, 0);
        drive(0);                 check("wrap", state_OUT, 0);
        drive(4, 0, 40, 1, 0);    check("cond_inv", state_OUT, 40);
        drive(4, 0, 40, 0, 1);    check("cond_pass", state_OUT, 40);
        drive(4, 0, 40, 0, 0);    check("cond_fail", state_OUT, 41);

        // Short memory wait
        drive(2, 0, 50);
        repeat (3) begin drive(3); check("wait_hold", state_OUT, 50); end
        drive(3, 0, 0, 0, 0, 1);  check("wait_done", state_OUT, 51);   check("wait_err", err_OUT, 0);

        // Timeout on the TIMEOUT-th miss
        repeat (TIMEOUT - 1) drive(3);
        check("to_pre_state", state_OUT, 51); check("to_pre_err", err_OUT, 0);
        drive(3);                 check("to_state", state_OUT, 127);   check("to_err", err_OUT, 1);
        pulse_clr();

        // moc arriving on the would-be timeout cycle wins
        drive(2, 0, 60);
        repeat (TIMEOUT - 1) drive(3);
        drive(3, 0, 0, 0, 0, 1);  check("moc_win_state", state_OUT, 61); check("moc_win_err", err_OUT, 0);

        // clr mid-wait restarts the miss counter
        drive(2, 0, 70);
        repeat (5) drive(3);
        pulse_clr();
        repeat (TIMEOUT - 1) drive(3);
        check("restart_state", state_OUT, 0); check("restart_err", err_OUT, 0);
        drive(3);                 check("restart_to", state_OUT, 127); check("restart_to_err", err_OUT, 1);
        pulse_clr();

        // Illegal select traps until clr
        drive(2, 0, 20);
        drive(6);                 check("ill_state", state_OUT, 127);  check("ill_err", err_OUT, 1);
        drive(5);                 check("trap_state", state_OUT, 127); check("trap_err", err_OUT, 1);
        drive(7);
        pulse_clr();

        // Randomized traffic
        prev_sel = 0;
        moc_bias = 5;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) moc_bias = $urandom_range(0, 9);
            if (m_err ? ($urandom % 16 == 0) : ($urandom % 400 == 0)) begin
                pulse_clr();
                prev_sel = 0;
            end else begin
                if (prev_sel == 3 && $urandom % 10 < 9) s = 3;
                else if ($urandom % 100 < 2) s = $urandom_range(6, 7);
                else s = $urandom_range(0, 5);
                drive(s,
                      ($urandom % 8 == 0) ? 0 : $urandom_range(0, NSTATES - 1),
                      $urandom_range(0, NSTATES - 1),
                      $urandom_range(0, 1), $urandom_range(0, 1),
                      ($urandom % 10) < moc_bias);
                prev_sel = s;
            end
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
